// File: rtl/arm_alu_register_file_pkg.sv
// Shared definitions for the ARM-style ALU + register file slice:
// ALU operation codes, condition-flag bit positions and the adder helper.
package arm_alu_register_file_pkg;

   // ALU operation codes (ARM data-processing order, then the extra ops)
   localparam logic [4:0] OP_AND  = 5'd0;
   localparam logic [4:0] OP_EOR  = 5'd1;
   localparam logic [4:0] OP_SUB  = 5'd2;
   localparam logic [4:0] OP_RSB  = 5'd3;
   localparam logic [4:0] OP_ADD  = 5'd4;
   localparam logic [4:0] OP_ADC  = 5'd5;
   localparam logic [4:0] OP_SBC  = 5'd6;
   localparam logic [4:0] OP_RSC  = 5'd7;
   localparam logic [4:0] OP_TST  = 5'd8;
   localparam logic [4:0] OP_TEQ  = 5'd9;
   localparam logic [4:0] OP_CMP  = 5'd10;
   localparam logic [4:0] OP_CMN  = 5'd11;
   localparam logic [4:0] OP_ORR  = 5'd12;
   localparam logic [4:0] OP_MOV  = 5'd13;
   localparam logic [4:0] OP_BIC  = 5'd14;
   localparam logic [4:0] OP_MVN  = 5'd15;
   localparam logic [4:0] OP_PASA = 5'd16;
   localparam logic [4:0] OP_PASB = 5'd17;
   localparam logic [4:0] OP_INC4 = 5'd18;
   localparam logic [4:0] OP_ADD4 = 5'd19;

   // Flag bit indices within {N,Z,C,V}
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef struct packed {
      logic [31:0] sum;
      logic        c;
      logic        v;
   } add_res_t;

   // 32-bit add with carry-in; subtraction is done as x + ~y + cin, so the
   // carry-out is directly the ARM "NOT borrow" convention.
   function automatic add_res_t add32(input logic [31:0] x,
                                      input logic [31:0] y,
                                      input logic        cin);
      add_res_t   res;
      logic [32:0] s;
      s       = {1'b0, x} + {1'b0, y} + {32'd0, cin};
      res.sum = s[31:0];
      res.c   = s[32];
      res.v   = (x[31] == y[31]) && (s[31] != x[31]);
      return res;
   endfunction

endpackage

// File: rtl/arm_alu_register_file_alu.sv
// Combinational ARM-style ALU with flag generation and a tri-stated result bus.
module arm_alu
   import arm_alu_register_file_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [4:0]  i_op,
   input  logic [3:0]  i_flags,
   input  logic        i_s,
   input  logic        i_alu_out,
   output logic [31:0] o_result,
   output logic [3:0]  o_flags,
   output tri   [31:0] o_out
);

   logic [31:0] w_result;
   logic        w_c;
   logic        w_v;
   logic        w_keep_flags;
   add_res_t    w_add;
   logic [33:0] w_sum4_u;
   logic [33:0] w_sum4_s;
   logic        w_cin;

   assign w_cin = i_flags[FLAG_C];

   // A+B+4 can carry twice past bit 31, so it gets its own wider adders
   assign w_sum4_u = {2'b00, i_a} + {2'b00, i_b} + 34'd4;
   assign w_sum4_s = {{2{i_a[31]}}, i_a} + {{2{i_b[31]}}, i_b} + 34'd4;

   // Operation decode: result plus carry/overflow; logical ops keep incoming C/V
   always_comb begin
      w_result     = 32'd0;
      w_c          = i_flags[FLAG_C];
      w_v          = i_flags[FLAG_V];
      w_keep_flags = 1'b0;
      w_add        = '0;
      case (i_op)
         OP_AND, OP_TST: w_result = i_a & i_b;
         OP_EOR, OP_TEQ: w_result = i_a ^ i_b;
         OP_ORR:         w_result = i_a | i_b;
         OP_MOV, OP_PASB: w_result = i_b;
         OP_BIC:         w_result = i_a & ~i_b;
         OP_MVN:         w_result = ~i_b;
         OP_PASA:        w_result = i_a;
         OP_SUB, OP_CMP: begin
            w_add = add32(i_a, ~i_b, 1'b1);
            w_result = w_add.sum; w_c = w_add.c; w_v = w_add.v;
         end
         OP_RSB: begin
            w_add = add32(i_b, ~i_a, 1'b1);
            w_result = w_add.sum; w_c = w_add.c; w_v = w_add.v;
         end
         OP_ADD, OP_CMN: begin
            w_add = add32(i_a, i_b, 1'b0);
            w_result = w_add.sum; w_c = w_add.c; w_v = w_add.v;
         end
         OP_ADC: begin
            w_add = add32(i_a, i_b, w_cin);
            w_result = w_add.sum; w_c = w_add.c; w_v = w_add.v;
         end
         OP_SBC: begin
            w_add = add32(i_a, ~i_b, w_cin);
            w_result = w_add.sum; w_c = w_add.c; w_v = w_add.v;
         end
         OP_RSC: begin
            w_add = add32(i_b, ~i_a, w_cin);
            w_result = w_add.sum; w_c = w_add.c; w_v = w_add.v;
         end
         OP_INC4: begin
            w_add = add32(i_a, 32'd4, 1'b0);
            w_result = w_add.sum; w_c = w_add.c; w_v = w_add.v;
         end
         OP_ADD4: begin
            w_result = w_sum4_u[31:0];
            w_c      = |w_sum4_u[33:32];
            w_v      = !((w_sum4_s[33:31] == 3'b000) || (w_sum4_s[33:31] == 3'b111));
         end
         default: begin
            // unused opcodes: zero result, flags untouched
            w_result     = 32'd0;
            w_keep_flags = 1'b1;
         end
      endcase
   end

   // Flag output: pass-through unless S is set on a defined opcode
   always_comb begin
      o_flags = i_flags;
      if (i_s && !w_keep_flags) begin
         o_flags[FLAG_N] = w_result[31];
         o_flags[FLAG_Z] = (w_result == 32'd0);
         o_flags[FLAG_C] = w_c;
         o_flags[FLAG_V] = w_v;
      end else begin
         o_flags = i_flags;
      end
   end

   assign o_result = w_result;
   assign o_out    = i_alu_out ? w_result : {32{1'bz}};

endmodule

// File: rtl/arm_alu_register_file_regfile.sv
// 16 x 32-bit register file, R15 doubles as the PC. Combinational reads,
// rising-edge writes, asynchronous active-low clear.
module regfile16x32
   import arm_alu_register_file_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [3:0]  i_rn_ir,
   input  logic [3:0]  i_rn_cu,
   input  logic        i_ir_cu,
   input  logic [3:0]  i_rm_sel,
   input  logic [3:0]  i_rs_sel,
   input  logic [3:0]  i_rd_sel,
   input  logic        i_load,
   input  logic [31:0] i_wdata,
   input  logic        i_loadpc,
   input  logic [31:0] i_pcin,
   output logic [31:0] o_rn,
   output logic [31:0] o_rm,
   output logic [31:0] o_rs,
   output logic [31:0] o_pc
);

   logic [31:0] r_regs [0:15];
   logic [3:0]  w_rn_sel;

   // Register storage; a PC load is placed last so it overrides an ALU write to R15
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 16; i++) begin
            r_regs[i] <= 32'd0;
         end
      end else begin
         if (i_load) begin
            r_regs[i_rd_sel] <= i_wdata;
         end
         if (i_loadpc) begin
            r_regs[4'd15] <= i_pcin;
         end
      end
   end

   assign w_rn_sel = i_ir_cu ? i_rn_ir : i_rn_cu;
   assign o_rn     = r_regs[w_rn_sel];
   assign o_rm     = r_regs[i_rm_sel];
   assign o_rs     = r_regs[i_rs_sel];
   assign o_pc     = r_regs[4'd15];

endmodule

// File: rtl/arm_alu_register_file.sv
// Top: register file feeding the ALU; the ALU result is the write-back data.
module arm_alu_register_file
   import arm_alu_register_file_pkg::*;
(
   input  logic        Clk,
   input  logic        RESET,
   input  logic [31:0] Pcin,
   input  logic [19:0] RSLCT,
   input  logic        LOADPC,
   input  logic        LOAD,
   input  logic        IR_CU,
   input  logic [4:0]  OP,
   input  logic [3:0]  FLAGS,
   input  logic        S,
   input  logic        ALU_OUT,
   output logic [31:0] Rn,
   output logic [31:0] Rm,
   output logic [31:0] Rs,
   output logic [31:0] PCout,
   output tri   [31:0] Out,
   output logic [3:0]  FLAGS_OUT
);

   logic [31:0] w_rn;
   logic [31:0] w_rm;
   logic [31:0] w_result;

   regfile16x32 u_regfile (
      .i_clk    (Clk),
      .i_rst_n  (RESET),
      .i_rn_ir  (RSLCT[3:0]),
      .i_rn_cu  (RSLCT[19:16]),
      .i_ir_cu  (IR_CU),
      .i_rm_sel (RSLCT[7:4]),
      .i_rs_sel (RSLCT[11:8]),
      .i_rd_sel (RSLCT[15:12]),
      .i_load   (LOAD),
      .i_wdata  (w_result),
      .i_loadpc (LOADPC),
      .i_pcin   (Pcin),
      .o_rn     (w_rn),
      .o_rm     (w_rm),
      .o_rs     (Rs),
      .o_pc     (PCout)
   );

   arm_alu u_alu (
      .i_a       (w_rn),
      .i_b       (w_rm),
      .i_op      (OP),
      .i_flags   (FLAGS),
      .i_s       (S),
      .i_alu_out (ALU_OUT),
      .o_result  (w_result),
      .o_flags   (FLAGS_OUT),
      .o_out     (Out)
   );

   assign Rn = w_rn;
   assign Rm = w_rm;

endmodule

// File: tb/tb_arm_alu_register_file.sv
// Self-checking bench: directed literal cases plus randomized traffic
// against a behavioural register-file/ALU model.
module tb_arm_alu_register_file;

   logic        Clk;
   logic        RESET;
   logic [31:0] Pcin;
   logic [19:0] RSLCT;
   logic        LOADPC;
   logic        LOAD;
   logic        IR_CU;
   logic [4:0]  OP;
   logic [3:0]  FLAGS;
   logic        S;
   logic        ALU_OUT;
   logic [31:0] Rn;
   logic [31:0] Rm;
   logic [31:0] Rs;
   logic [31:0] PCout;
   tri1  [31:0] Out;
   logic [3:0]  FLAGS_OUT;

   int n_cmp;
   int n_err;
   bit chk_en;
   logic [31:0] m_regs [16];

   arm_alu_register_file dut (
      .Clk(Clk), .RESET(RESET), .Pcin(Pcin), .RSLCT(RSLCT), .LOADPC(LOADPC),
      .LOAD(LOAD), .IR_CU(IR_CU), .OP(OP), .FLAGS(FLAGS), .S(S),
      .ALU_OUT(ALU_OUT), .Rn(Rn), .Rm(Rm), .Rs(Rs), .PCout(PCout),
      .Out(Out), .FLAGS_OUT(FLAGS_OUT)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference ALU from exact integer arithmetic: carry = result outside
   // 0..2^32-1 (or no borrow), overflow = signed value outside int range.
   function automatic void model_alu(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [3:0] fl,
                                     input logic s, output logic [31:0] res,
                                     output logic [3:0] fo);
      longint ua, ub, sa, sb, sv, cin, nb;
      bit arith, c;
      ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
      sa = longint'($signed(a)); sb = longint'($signed(b));
      cin = longint'(fl[1]); nb = 64'sd1 - cin;
      arith = 1'b1; c = 1'b0; sv = 0; res = 32'd0;
      case (op)
         5'd0, 5'd8:  begin arith = 1'b0; res = a & b; end
         5'd1, 5'd9:  begin arith = 1'b0; res = a ^ b; end
         5'd12:       begin arith = 1'b0; res = a | b; end
         5'd13, 5'd17: begin arith = 1'b0; res = b; end
         5'd14:       begin arith = 1'b0; res = a & ~b; end
         5'd15:       begin arith = 1'b0; res = ~b; end
         5'd16:       begin arith = 1'b0; res = a; end
         5'd2, 5'd10: begin c = (ua >= ub);       sv = sa - sb; end
         5'd3:        begin c = (ub >= ua);       sv = sb - sa; end
         5'd4, 5'd11: begin c = (ua + ub > 64'sd4294967295); sv = sa + sb; end
         5'd5:        begin c = (ua + ub + cin > 64'sd4294967295); sv = sa + sb + cin; end
         5'd6:        begin c = (ua >= ub + nb);  sv = sa - sb - nb; end
         5'd7:        begin c = (ub >= ua + nb);  sv = sb - sa - nb; end
         5'd18:       begin c = (ua + 4 > 64'sd4294967295); sv = sa + 4; end
         5'd19:       begin c = (ua + ub + 4 > 64'sd4294967295); sv = sa + sb + 4; end
         default: begin
            res = 32'd0; fo = fl;
            return;
         end
      endcase
      if (arith) res = sv[31:0];
      fo = fl;
      if (s) begin
         fo[3] = res[31];
         fo[2] = (res == 32'd0);
         if (arith) begin
            fo[1] = c;
            fo[0] = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
         end
      end
   endfunction

   // Model state update on each clock edge outside reset
   always @(posedge Clk) begin
      logic [31:0] a, res;
      logic [3:0]  fo;
      if (RESET === 1'b1) begin
         a = m_regs[IR_CU ? RSLCT[3:0] : RSLCT[19:16]];
         model_alu(OP, a, m_regs[RSLCT[7:4]], FLAGS, S, res, fo);
         if (LOAD) m_regs[RSLCT[15:12]] = res;
         if (LOADPC) m_regs[15] = Pcin;
      end
   end

   // Model clear on reset assertion
   always @(negedge RESET) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
   end

   // Per-cycle comparison of every output against the model
   always @(negedge Clk) begin
      logic [31:0] a, res;
      logic [3:0]  fo;
      if (chk_en) begin
         a = m_regs[IR_CU ? RSLCT[3:0] : RSLCT[19:16]];
         model_alu(OP, a, m_regs[RSLCT[7:4]], FLAGS, S, res, fo);
         check("Rn", Rn, a);
         check("Rm", Rm, m_regs[RSLCT[7:4]]);
         check("Rs", Rs, m_regs[RSLCT[11:8]]);
         check("PCout", PCout, m_regs[15]);
         check("Out", Out, ALU_OUT ? res : 32'hFFFF_FFFF);
         check("FLAGS_OUT", {28'd0, FLAGS_OUT}, {28'd0, fo});
      end
   end

   function automatic logic [19:0] rsl(input logic [3:0] rncu, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [3:0] rm,
                                       input logic [3:0] rn);
      return {rncu, rd, rs, rm, rn};
   endfunction

   task automatic drive(input logic [19:0] sel, input logic [4:0] op, input logic ld,
                        input logic ldpc, input logic [31:0] pc, input logic ircu,
                        input logic s, input logic [3:0] fl, input logic aout);
      @(posedge Clk); #1;
      RSLCT = sel; OP = op; LOAD = ld; LOADPC = ldpc; Pcin = pc;
      IR_CU = ircu; S = s; FLAGS = fl; ALU_OUT = aout;
   endtask

   task automatic settle();
      @(negedge Clk); #1;
   endtask

   initial begin
      logic [31:0] rnd;
      n_cmp = 0; n_err = 0; chk_en = 1'b0;
      for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
      RESET = 1'b0; Pcin = 32'd0; RSLCT = 20'd0; LOADPC = 1'b0; LOAD = 1'b0;
      IR_CU = 1'b1; OP = 5'd0; FLAGS = 4'd0; S = 1'b0; ALU_OUT = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      check("reset_pc", PCout, 32'd0);
      check("reset_rn", Rn, 32'd0);
      RESET = 1'b1;
      chk_en = 1'b1;

      // R1 = R0 + 4, then pass R1 back into itself
      drive(rsl(4'd0, 4'd1, 4'd0, 4'd0, 4'd0), 5'd18, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 1'b1);
      settle(); check("inc4_out", Out, 32'd4);
      drive(rsl(4'd0, 4'd1, 4'd0, 4'd1, 4'd1), 5'd16, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 1'b1);
      settle(); check("r1_is_4", Rn, 32'd4); check("pass_out", Out, 32'd4);
      // LOADPC beats LOAD to R15
      drive(rsl(4'd0, 4'd15, 4'd0, 4'd1, 4'd1), 5'd16, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 4'd0, 1'b1);
      drive(rsl(4'd0, 4'd0, 4'd0, 4'd1, 4'd1), 5'd16, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 1'b1);
      settle(); check("pc_wins", PCout, 32'h100); check("r1_kept", Rn, 32'd4);
      // R1 = ~R0, R2 = R0 - R1 = 1, then ADD R1+R2
      drive(rsl(4'd0, 4'd1, 4'd0, 4'd0, 4'd0), 5'd15, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 1'b1);
      drive(rsl(4'd0, 4'd2, 4'd0, 4'd1, 4'd0), 5'd2, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 1'b1);
      drive(rsl(4'd0, 4'd0, 4'd0, 4'd2, 4'd1), 5'd4, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 4'd0, 1'b1);
      settle(); check("add_out", Out, 32'd0); check("add_flags", {28'd0, FLAGS_OUT}, 32'h6);
      check("r2_is_1", Rm, 32'd1);
      drive(rsl(4'd0, 4'd0, 4'd0, 4'd2, 4'd1), 5'd4, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 4'b1001, 1'b1);
      settle(); check("s0_flags", {28'd0, FLAGS_OUT}, 32'h9);
      // CMP 0x7FFFFFFF - 1 and 0x80000000 - 1, operands staged through R15
      drive(rsl(4'd0, 4'd0, 4'd0, 4'd0, 4'd0), 5'd0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 4'd0, 1'b1);
      drive(rsl(4'd0, 4'd3, 4'd0, 4'd15, 4'd0), 5'd13, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 1'b1);
      drive(rsl(4'd0, 4'd0, 4'd0, 4'd2, 4'd3), 5'd10, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 4'd0, 1'b1);
      settle(); check("cmp1_out", Out, 32'h7FFF_FFFE); check("cmp1_flags", {28'd0, FLAGS_OUT}, 32'h2);
      drive(rsl(4'd0, 4'd0, 4'd0, 4'd0, 4'd0), 5'd0, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 4'd0, 1'b1);
      drive(rsl(4'd0, 4'd4, 4'd0, 4'd15, 4'd0), 5'd13, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 1'b1);
      drive(rsl(4'd0, 4'd0, 4'd0, 4'd2, 4'd4), 5'd10, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 4'd0, 1'b1);
      settle(); check("cmp2_out", Out, 32'h7FFF_FFFF); check("cmp2_flags", {28'd0, FLAGS_OUT}, 32'h3);
      // Rn source select and tri-state (undriven bus reads as pulled-up ones)
      drive(rsl(4'd2, 4'd0, 4'd0, 4'd0, 4'd1), 5'd16, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 1'b1);
      settle(); check("ircu1_rn", Rn, 32'hFFFF_FFFF);
      drive(rsl(4'd2, 4'd0, 4'd0, 4'd0, 4'd1), 5'd16, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      settle(); check("ircu0_rn", Rn, 32'd1); check("hiz_out", Out, 32'hFFFF_FFFF);

      // Randomized traffic with one asynchronous reset pulse mid-run
      for (int i = 0; i < 400; i++) begin
         @(posedge Clk); #1;
         rnd = $urandom; RSLCT = rnd[19:0];
         rnd = $urandom; OP = (rnd[7:0] < 8'd220) ? 5'(rnd[15:8] % 20) : rnd[20:16];
         LOAD = rnd[21]; LOADPC = (rnd[24:22] == 3'd0); IR_CU = rnd[25];
         S = rnd[26]; ALU_OUT = (rnd[29:27] != 3'd0); FLAGS = {rnd[30], rnd[31], rnd[0], rnd[1]};
         Pcin = $urandom;
         if (i == 200) begin
            #2 RESET = 1'b0;
            #1;
            check("arst_rn", Rn, 32'd0); check("arst_rm", Rm, 32'd0);
            check("arst_rs", Rs, 32'd0); check("arst_pc", PCout, 32'd0);
            @(posedge Clk); #3 RESET = 1'b1;
         end
      end
      @(negedge Clk); #1;
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
